fir_result_checker: RTL

- Parametrised, synthesizable successor to the single-channel FIR self-check logic.
- Queues expected results, aligns them to DUT outputs of unknown latency, and compares NUM_CHANNELS lanes per beat.
- Counts mismatching beats, detects underflow and timeout, and reports done/pass as signals, so it can run on-chip as well as in simulation.
- Sits between a stimulus/golden-vector source and one or more FIR filter instances.

---
 rtl/fir_result_checker.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/fir_result_checker.sv
// fir_result_checker
//   Queues golden FIR results, aligns them to DUT output beats of unknown
//   latency and compares NUM_CHANNELS lanes per beat. Reports mismatching
//   beats, underflow (DUT beat with nothing queued) and an idle-DUT timeout,
//   and finishes with done/pass so the check can run on-chip.
//
//   Handshake: an expected beat transfers on a rising edge where exp_valid
//   and exp_ready are both high. exp_ready does not depend on exp_valid. The
//   DUT side has no ready: each cycle with dut_valid high is one beat.
//
//   Optional build macro FIRST_ERROR_CAPTURE_EN adds first-failure capture
//   ports (index, channel, expected and received value of the first failing
//   beat after start).
//
// Ports:
//   clk, resetn         clock (rising edge), asynchronous active-low reset
//   start               one-cycle pulse, begins a run from IDLE or DONE
//   exp_valid/exp_data  expected beat offered; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   exp_ready           expected beat accepted this cycle
//   dut_valid/dut_data  DUT result beat, same packing as exp_data
//   mismatch            registered; the previous compared beat failed
//   error_count         failing beats (mismatch or underflow), saturating
//   vector_count        beats compared
//   underflow, timeout  sticky error flags
//   done, pass          run finished; pass valid while done is high
module fir_result_checker #(
    parameter int DATA_WIDTH      = 37,
    parameter int NUM_CHANNELS    = 1,
    parameter int FIFO_DEPTH      = 16,
    parameter int NUM_VECTORS     = 256,
    parameter int ERR_COUNT_WIDTH = 16,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int BUS_W = NUM_CHANNELS * DATA_WIDTH,
    localparam int VC_W  = $clog2(NUM_VECTORS) + 1,
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic                       exp_valid,
    input  logic [BUS_W-1:0]           exp_data,
    output logic                       exp_ready,
    input  logic                       dut_valid,
    input  logic [BUS_W-1:0]           dut_data,
    output logic                       mismatch,
    output logic [ERR_COUNT_WIDTH-1:0] error_count,
    output logic [VC_W-1:0]            vector_count,
    output logic                       underflow,
    output logic                       timeout,
    output logic                       done,
    output logic                       pass
`ifdef FIRST_ERROR_CAPTURE_EN
    ,
    output logic [VC_W-1:0]            first_err_index,
    output logic [CH_W-1:0]            first_err_channel,
    output logic [DATA_WIDTH-1:0]      first_err_expected,
    output logic [DATA_WIDTH-1:0]      first_err_received
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
    state_t state;

    // Expected-value FIFO; pointers carry one extra wrap bit for full/empty.
    logic [BUS_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full;
    logic [BUS_W-1:0] head;

    logic [VC_W-1:0]         push_count;
    logic [WD_W-1:0]         wd_cnt;
    logic [NUM_CHANNELS-1:0] ch_neq;
    logic active, push, pop, uflow, beat_fail, err_inc, wd_expire;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

    assign active    = (state == ST_RUN) || (state == ST_DRAIN);
    assign exp_ready = (state == ST_RUN) && !fifo_full;
    assign push      = exp_valid && exp_ready;
    // No bypass: a DUT beat against an empty FIFO is an underflow even if a
    // push lands on the same edge.
    assign pop       = active && dut_valid && !fifo_empty;
    assign uflow     = active && dut_valid && fifo_empty;

    always_comb begin
        ch_neq = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            ch_neq[c] = (head[c*DATA_WIDTH +: DATA_WIDTH] != dut_data[c*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    assign beat_fail = |ch_neq;
    assign err_inc   = (pop && beat_fail) || uflow;
    // Watchdog fires on the edge that would make the idle count reach TIMEOUT_CYCLES.
    assign wd_expire = active && !dut_valid && !fifo_empty &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    assign done = (state == ST_DONE);
    assign pass = done && (error_count == '0) && !underflow && !timeout;

    // FIFO storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= exp_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            push_count   <= '0;
            wd_cnt       <= '0;
            mismatch     <= 1'b0;
            error_count  <= '0;
            vector_count <= '0;
            underflow    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state        <= ST_RUN;
                        wr_ptr       <= '0;
                        rd_ptr       <= '0;
                        push_count   <= '0;
                        wd_cnt       <= '0;
                        mismatch     <= 1'b0;
                        error_count  <= '0;
                        vector_count <= '0;
                        underflow    <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end
                default: begin  // ST_RUN, ST_DRAIN
                    if (push) begin
                        wr_ptr     <= wr_ptr + (PTR_W+1)'(1);
                        push_count <= push_count + VC_W'(1);
                    end
                    if (pop) begin
                        rd_ptr       <= rd_ptr + (PTR_W+1)'(1);
                        vector_count <= vector_count + VC_W'(1);
                        mismatch     <= beat_fail;
                    end else begin
                        mismatch <= 1'b0;
                    end
                    if (uflow) begin
                        underflow <= 1'b1;
                    end
                    if (err_inc && !(&error_count)) begin
                        error_count <= error_count + ERR_COUNT_WIDTH'(1);
                    end
                    if (dut_valid) begin
                        wd_cnt <= '0;
                    end else if (!fifo_empty) begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end

                    if (wd_expire) begin
                        timeout <= 1'b1;
                        state   <= ST_DONE;
                    end else if (state == ST_RUN && push &&
                                 push_count == VC_W'(NUM_VECTORS - 1)) begin
                        state <= ST_DRAIN;
                    end else if (state == ST_DRAIN &&
                                 vector_count == VC_W'(NUM_VECTORS)) begin
                        state <= ST_DONE;
                    end
                end
            endcase
        end
    end

`ifdef FIRST_ERROR_CAPTURE_EN
    logic [CH_W-1:0]       first_ch;
    logic [DATA_WIDTH-1:0] first_exp, first_rcv;
    logic                  first_seen;

    // Descending scan so the lowest failing channel wins.
    always_comb begin
        first_ch  = '0;
        first_exp = '0;
        first_rcv = '0;
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (ch_neq[c]) begin
                first_ch  = CH_W'(c);
                first_exp = head[c*DATA_WIDTH +: DATA_WIDTH];
                first_rcv = dut_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            first_seen         <= 1'b0;
            first_err_index    <= '0;
            first_err_channel  <= '0;
            first_err_expected <= '0;
            first_err_received <= '0;
        end else if ((state == ST_IDLE || state == ST_DONE) && start) begin
            first_seen         <= 1'b0;
            first_err_index    <= '0;
            first_err_channel  <= '0;
            first_err_expected <= '0;
            first_err_received <= '0;
        end else if (pop && beat_fail && !first_seen) begin
            first_seen         <= 1'b1;
            first_err_index    <= vector_count;
            first_err_channel  <= first_ch;
            first_err_expected <= first_exp;
            first_err_received <= first_rcv;
        end
    end
`endif

endmodule
